nibble_serial_add_ctrl: RTL

- Sequencer that computes WIDTH-bit add/subtract by time-multiplexing the team's existing 4-bit ripple adder (4-bit A/B, carry-in, 4-bit sum, carry-out).
- Feeds one nibble per clock, least significant first, and chains the carry through a register.
- Collects the sum and reports carry, signed overflow and completion.
- Sits between operand sources (switch/register logic) and one external 4-bit adder instance, which it owns exclusively.

---
 rtl/nibble_serial_add_ctrl_if.sv | 29 ++
 rtl/nibble_serial_add_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake plus the borrowed 4-bit adder port for nibble_serial_add_ctrl.
// slave is the controller side; master is the operand source / adder owner side.
interface nibble_serial_add_ctrl_if #(parameter int WIDTH = 16);
    logic             start_i;
    logic             sub_i;
    logic             cin_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [3:0]       add_a_o;
    logic [3:0]       add_b_o;
    logic             add_cin_o;
    logic [3:0]       add_s_i;
    logic             add_cout_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  start_i, sub_i, cin_i, a_i, b_i, add_s_i, add_cout_i,
        output add_a_o, add_b_o, add_cin_o, sum_o, cout_o, ovf_o, busy_o, done_o
    );

    modport master (
        output start_i, sub_i, cin_i, a_i, b_i, add_s_i, add_cout_i,
        input  add_a_o, add_b_o, add_cin_o, sum_o, cout_o, ovf_o, busy_o, done_o
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through an external 4-bit adder.
//
// state | meaning
// IDLE  | waiting for start_i; adder port driven 0; last result held
// RUN   | feeding nibble k (LSB first), chaining carry through carry_q
// DONE  | one-cycle done_o pulse; result registers already updated
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    nibble_serial_add_ctrl_if.slave   bus
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0][3:0]  a_q, b_q, sum_q, sum_d;
    logic               sub_q, cin_q, carry_q;
    logic [KW-1:0]      k_q;
    logic               last_step;
    logic [WIDTH-1:0]   sum_o_q;
    logic               cout_q, ovf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        last_step     = (k_q == KW'(N - 1));
        bus.add_a_o   = 4'h0;
        bus.add_b_o   = 4'h0;
        bus.add_cin_o = 1'b0;
        bus.busy_o    = 1'b0;
        bus.done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                bus.busy_o    = 1'b1;
                bus.add_a_o   = a_q[k_q];
                bus.add_b_o   = b_q[k_q];
                bus.add_cin_o = (k_q == '0) ? (sub_q | cin_q) : carry_q;
                sum_d[k_q]    = bus.add_s_i;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                bus.busy_o = 1'b1;
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // b_q holds the effective B operand, already inverted for subtract
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_o_q <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        a_q     <= bus.a_i;
                        b_q     <= bus.sub_i ? ~bus.b_i : bus.b_i;
                        sub_q   <= bus.sub_i;
                        cin_q   <= bus.cin_i;
                        carry_q <= 1'b0;
                        k_q     <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= bus.add_cout_i;
                    k_q     <= k_q + KW'(1);
                    if (last_step) begin
                        sum_o_q <= sum_d;
                        cout_q  <= bus.add_cout_i;
                        ovf_q   <= (a_q[N-1][3] == b_q[N-1][3]) &&
                                   (sum_d[N-1][3] != a_q[N-1][3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum_o  = sum_o_q;
    assign bus.cout_o = cout_q;
    assign bus.ovf_o  = ovf_q;
endmodule
